mtrx_chain_mult: RTL
====================

MTRX_CHAIN_MULT -- requirements
Module: mtrx_chain_mult

Interface
REQ-001 SHALL have parameter FRAC_LIN, default 5: fractional bits of input, shifting and projection matrices (Q1.10.5).
REQ-002 SHALL have parameter FRAC_ROT, default 13: fractional bits of rotation matrices (Q1.2.13).
REQ-003 SHALL have port CLK, input, 1, system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port CPUvalid, input, 1, frame-active qualifier from the CPU stage.
REQ-006 SHALL have port matrixState, input, 4, code of the matrix on mtrxIn: 1 input, 2 rotX, 3 rotY, 4 rotZ, 5 shift, 6 projection; other values mean no matrix.
REQ-007 SHALL have port mtrxIn, input, 256, signed 4x4 matrix; element (r,c) at bits [16*(4r+c)+15 : 16*(4r+c)].
REQ-008 SHALL have port result, output, 256, final transformed vertex matrix in Q1.10.5, same packing.
REQ-009 SHALL have port resultValid, output, 1, one-cycle pulse when result updates.
REQ-010 SHALL have port busy, output, 1, high while a row multiply is in progress.
REQ-011 SHALL have port satFlag, output, 1, sticky per frame: some element saturated.
REQ-012 SHALL have port seqErr, output, 1, sticky per frame: out-of-order matrixState seen.

Function
REQ-013 SHALL register last-seen matrixState (prevState); a capture event is a CLK edge with CPUvalid=1, matrixState in 1..6 and matrixState != prevState.
REQ-014 SHALL, on capture of state 1, load mtrxIn into accumulator ACC directly, clear satFlag and seqErr, and enter WAIT.
REQ-015 SHALL, on capture of state k in 2..6 with k == prevState+1 and FSM in WAIT, latch mtrxIn as M and enter MUL; ACC <= M x ACC.
REQ-016 SHALL, in MUL, compute one result row per cycle, row counter 0..3; ACC row written after all four rows computed, so M x ACC uses the old ACC throughout; MUL lasts exactly 4 cycles.
REQ-017 SHALL compute each element as sum of four 16x16 signed products in 34-bit, add 2^(F-1), arithmetic shift right F, saturate to [-32768, 32767]; F = FRAC_ROT for states 2-4, FRAC_LIN for 5-6.
REQ-018 SHALL set satFlag when any saturation clamps a value.
REQ-019 SHALL, after the MUL for state 6 completes, copy ACC to result and pulse resultValid one cycle later than the last row (capture edge t -> resultValid high in cycle t+5), then enter IDLE.
REQ-020 SHALL, on a capture event that is out of order (state != prevState+1, or state 2..6 while not WAIT), set seqErr, ignore the matrix, and go to IDLE until next state-1 capture.
REQ-021 SHALL ignore capture events while busy (cannot occur with the 7-cycle state hold; sets seqErr if it does).
REQ-022 SHALL, when CPUvalid=0, return FSM to IDLE and clear prevState to 0 within one cycle; abort any MUL; result, satFlag and seqErr hold.
REQ-023 SHALL hold result stable between resultValid pulses.
REQ-024 SHALL have FSM states IDLE, WAIT, MUL, DONE; DONE lasts one cycle and drives resultValid.

Reset
REQ-025 SHALL, on rst, asynchronously set result=0, resultValid=0, busy=0, satFlag=0, seqErr=0, ACC=0, M=0, prevState=0, row counter 0, FSM IDLE.
REQ-026 SHALL, on rst asserted mid-MUL, discard the partial product; no resultValid follows.

Structure
REQ-027 SHALL take element width 16, FRAC_LIN/FRAC_ROT defaults, matrixState codes 1..6 and element index helper from shared package mgpu_pkg.
REQ-028 SHALL instantiate one sub-module mtrx_row_mac: one ACC column-set x one M row -> four rounded, saturated 16-bit elements plus saturation bit; combinational, reused per row.

Verification
REQ-029 SHALL verify identity chain: input all elements 32, states 2-4 identity (diag 8192), 5-6 identity (diag 32) -> result all elements 32, resultValid once, satFlag=0.
REQ-030 SHALL verify rotZ 90 deg: input col0 = (32,0,0,32), rotZ rows (0,-8192,0,0)/(8192,0,0,0)/(0,0,8192,0)/(0,0,0,8192), others identity -> result col0 = (0,32,0,32).
REQ-031 SHALL verify saturation: shift matrix diag 32 with element (0,3)=32767, input (0,0)=32767, (3,0)=32 -> result (0,0)=32767, satFlag=1.
REQ-032 SHALL verify sequence error: states 1,2,4 -> seqErr=1, no resultValid; following clean frame 1..6 -> seqErr cleared at state 1, resultValid once.
REQ-033 SHALL verify CPUvalid drop during state 4 MUL -> FSM IDLE next cycle, no resultValid, previous result unchanged.
REQ-034 SHALL verify rst asserted mid-MUL -> all outputs 0 same cycle, no resultValid after release.

Source files
------------

// File: rtl/mgpu_pkg.sv
// ============================================================================
// mgpu_pkg : shared widths, fixed-point defaults, matrix codes, FSM type
// Revision : 1.0
// ============================================================================
`default_nettype none
package mgpu_pkg;
  localparam int c_ELEM_W   = 16;
  localparam int c_FRAC_LIN = 5;
  localparam int c_FRAC_ROT = 13;

  localparam logic [3:0] c_ST_INPUT = 4'd1;
  localparam logic [3:0] c_ST_ROTX  = 4'd2;
  localparam logic [3:0] c_ST_ROTY  = 4'd3;
  localparam logic [3:0] c_ST_ROTZ  = 4'd4;
  localparam logic [3:0] c_ST_SHIFT = 4'd5;
  localparam logic [3:0] c_ST_PROJ  = 4'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } mcm_state_t;

  // Bit offset of element (r,c) in a packed 4x4 matrix
  function automatic int elem_idx(input int r, input int c);
    return c_ELEM_W * (4 * r + c);
  endfunction
endpackage
`default_nettype wire

// File: rtl/mtrx_row_mac.sv
// ============================================================================
// mtrx_row_mac : one M row times full ACC -> four rounded, saturated elements
// Revision     : 1.0
// ============================================================================
`default_nettype none
module mtrx_row_mac
  import mgpu_pkg::*;
#(
  parameter int FRAC_LIN = c_FRAC_LIN,
  parameter int FRAC_ROT = c_FRAC_ROT
) (
  input  logic [4*c_ELEM_W-1:0]  i_mrow,
  input  logic [16*c_ELEM_W-1:0] i_acc,
  input  logic                   i_rot,
  output logic [4*c_ELEM_W-1:0]  o_row,
  output logic                   o_sat
);
  localparam logic signed [33:0] c_RND_ROT = 34'sd1 <<< (FRAC_ROT - 1);
  localparam logic signed [33:0] c_RND_LIN = 34'sd1 <<< (FRAC_LIN - 1);
  localparam logic signed [33:0] c_MAX     = 34'sd32767;
  localparam logic signed [33:0] c_MIN     = -34'sd32768;

  logic signed [15:0] w_a, w_b;
  logic signed [31:0] w_p;
  logic signed [33:0] w_sum, w_rnd, w_shr;

  always_comb begin
    o_row = '0;
    o_sat = 1'b0;
    w_a   = '0;
    w_b   = '0;
    w_p   = '0;
    w_sum = '0;
    w_rnd = '0;
    w_shr = '0;
    for (int c = 0; c < 4; c++) begin
      w_sum = '0;
      for (int k = 0; k < 4; k++) begin
        w_a   = i_mrow[c_ELEM_W*k +: c_ELEM_W];
        w_b   = i_acc[elem_idx(k, c) +: c_ELEM_W];
        w_p   = 32'(w_a) * 32'(w_b);
        w_sum = w_sum + {{2{w_p[31]}}, w_p};
      end
      w_rnd = w_sum + (i_rot ? c_RND_ROT : c_RND_LIN);
      w_shr = i_rot ? (w_rnd >>> FRAC_ROT) : (w_rnd >>> FRAC_LIN);
      if (w_shr > c_MAX) begin
        o_row[c_ELEM_W*c +: c_ELEM_W] = 16'h7FFF;
        o_sat = 1'b1;
      end else if (w_shr < c_MIN) begin
        o_row[c_ELEM_W*c +: c_ELEM_W] = 16'h8000;
        o_sat = 1'b1;
      end else begin
        o_row[c_ELEM_W*c +: c_ELEM_W] = w_shr[15:0];
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/mtrx_chain_mult.sv
// ============================================================================
// mtrx_chain_mult : accumulates P x S x Rz x Ry x Rx x In, one row per cycle
// Revision        : 1.0
// ============================================================================
`default_nettype none
module mtrx_chain_mult
  import mgpu_pkg::*;
#(
  parameter int FRAC_LIN = c_FRAC_LIN,
  parameter int FRAC_ROT = c_FRAC_ROT
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         CPUvalid,
  input  logic [3:0]   matrixState,
  input  logic [255:0] mtrxIn,
  output logic [255:0] result,
  output logic         resultValid,
  output logic         busy,
  output logic         satFlag,
  output logic         seqErr
);
  mcm_state_t   r_state;
  logic [3:0]   r_prev;
  logic [3:0]   r_k;
  logic [1:0]   r_row;
  logic [255:0] r_acc;
  logic [255:0] r_m;
  logic [191:0] r_tmp;
  logic [63:0]  w_row;
  logic         w_sat;
  logic         w_rot;
  logic         w_cap;

  assign w_cap = CPUvalid && (matrixState >= c_ST_INPUT) &&
                 (matrixState <= c_ST_PROJ) && (matrixState != r_prev);
  assign w_rot = (r_k >= c_ST_ROTX) && (r_k <= c_ST_ROTZ);

  mtrx_row_mac #(
    .FRAC_LIN (FRAC_LIN),
    .FRAC_ROT (FRAC_ROT)
  ) u_row_mac (
    .i_mrow (r_m[r_row*64 +: 64]),
    .i_acc  (r_acc),
    .i_rot  (w_rot),
    .o_row  (w_row),
    .o_sat  (w_sat)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_prev      <= '0;
      r_k         <= '0;
      r_row       <= '0;
      r_acc       <= '0;
      r_m         <= '0;
      r_tmp       <= '0;
      result      <= '0;
      resultValid <= 1'b0;
      busy        <= 1'b0;
      satFlag     <= 1'b0;
      seqErr      <= 1'b0;
    end else if (!CPUvalid) begin
      r_state     <= S_IDLE;
      r_prev      <= '0;
      r_row       <= '0;
      busy        <= 1'b0;
      resultValid <= 1'b0;
    end else begin
      resultValid <= 1'b0;
      r_prev      <= matrixState;
      case (r_state)
        S_MUL: begin
          r_row <= r_row + 2'd1;
          if (w_sat) satFlag <= 1'b1;
          // Rows are staged so the whole product reads the old ACC
          case (r_row)
            2'd0:    r_tmp[63:0]    <= w_row;
            2'd1:    r_tmp[127:64]  <= w_row;
            2'd2:    r_tmp[191:128] <= w_row;
            default: begin
              r_acc   <= {w_row, r_tmp};
              busy    <= 1'b0;
              r_state <= (r_k == c_ST_PROJ) ? S_DONE : S_WAIT;
            end
          endcase
        end
        S_DONE: begin
          result      <= r_acc;
          resultValid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: ;
      endcase
      if (w_cap) begin
        if (r_state == S_MUL) begin
          seqErr <= 1'b1;
        end else if (matrixState == c_ST_INPUT) begin
          r_acc   <= mtrxIn;
          satFlag <= 1'b0;
          seqErr  <= 1'b0;
          r_state <= S_WAIT;
        end else if ((r_state == S_WAIT) && (matrixState == r_prev + 4'd1)) begin
          r_m     <= mtrxIn;
          r_k     <= matrixState;
          r_row   <= '0;
          busy    <= 1'b1;
          r_state <= S_MUL;
        end else begin
          seqErr  <= 1'b1;
          r_state <= S_IDLE;
        end
      end
    end
  end
endmodule
`default_nettype wire
